// File: rtl/hqm_AW_pkg.sv
// Shared types and helpers for the hqm_AW scheduler family.
package hqm_AW_pkg;

  typedef enum logic {
    AW_DS_IDLE  = 1'b0,
    AW_DS_BURST = 1'b1
  } aw_drain_sched_state_t;

  // floor(log2(v)); returns 0 for v <= 1.
  function automatic int AW_logb2(input int v);
    int r;
    r = 0;
    for (int t = v; t > 1; t = t >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/hqm_AW_rr_next_sel.sv
// First set request strictly after i_ptr, wrapping; i_ptr itself is checked last.
// Purely combinational, no backpressure.
module hqm_AW_rr_next_sel
  import hqm_AW_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDXWIDTH = AW_logb2(NUM_REQ - 1) + 1
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDXWIDTH-1:0] i_ptr,
  output logic                o_found,
  output logic [IDXWIDTH-1:0] o_idx
);

  always_comb begin
    logic [IDXWIDTH-1:0] w_cand;
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDXWIDTH'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/hqm_aw_fifo_drain_sched.sv
// Weighted round-robin drain of NUM_REQ FIFOs into one registered valid/ready stage.
// Pop in cycle N appears on out_* in N+1; out_valid & ~out_ready freezes pops and all state.
module hqm_aw_fifo_drain_sched
  import hqm_AW_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DWIDTH   = 16,
  parameter int WTWIDTH  = 4,
  parameter int IDXWIDTH = AW_logb2(NUM_REQ - 1) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          cfg_enable,
  input  logic [NUM_REQ*WTWIDTH-1:0]  cfg_weight,
  input  logic [NUM_REQ-1:0]          fifo_empty,
  output logic [NUM_REQ-1:0]          fifo_pop,
  input  logic [NUM_REQ*DWIDTH-1:0]   fifo_pop_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DWIDTH-1:0]           out_data,
  output logic [IDXWIDTH-1:0]         out_idx,
  output logic                        sched_idle
);

  aw_drain_sched_state_t r_state, w_state_nxt;
  logic [IDXWIDTH-1:0]   r_owner, w_owner_nxt, w_rr_idx, w_grant_idx;
  logic [WTWIDTH-1:0]    r_burst_cnt, w_burst_cnt_nxt, w_own_wt, w_burst_lim;
  logic                  w_rr_found, w_accept, w_continue, w_grant;
  logic [NUM_REQ-1:0]    w_eligible;
  logic [DWIDTH-1:0]     w_head   [NUM_REQ];
  logic [WTWIDTH-1:0]    w_weight [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_head[i]   = fifo_pop_data[i*DWIDTH +: DWIDTH];
      w_weight[i] = cfg_weight[i*WTWIDTH +: WTWIDTH];
    end
  end

  assign w_eligible = cfg_enable & ~fifo_empty;
  assign w_accept   = ~out_valid | out_ready;
  assign w_own_wt   = w_weight[r_owner];
  assign sched_idle = ~out_valid & ~(|w_eligible);

  hqm_AW_rr_next_sel #(
    .NUM_REQ  (NUM_REQ),
    .IDXWIDTH (IDXWIDTH)
  ) u_rr_next_sel (
    .i_req   (w_eligible),
    .i_ptr   (r_owner),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  // Pop is gated by rst_n so nothing is drained while reset is held.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_grant         = 1'b0;
    w_grant_idx     = r_owner;
    w_burst_lim     = (w_own_wt == '0) ? '0 : w_own_wt - 1'b1;
    w_continue      = (r_state == AW_DS_BURST) && w_eligible[r_owner] &&
                      (r_burst_cnt < w_burst_lim);
    if (rst_n && w_accept) begin
      if (w_continue) begin
        w_grant         = 1'b1;
        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
      end else if (w_rr_found) begin
        w_grant         = 1'b1;
        w_grant_idx     = w_rr_idx;
        w_owner_nxt     = w_rr_idx;
        w_burst_cnt_nxt = '0;
        w_state_nxt     = AW_DS_BURST;
      end else begin
        w_state_nxt     = AW_DS_IDLE;
      end
    end
    fifo_pop = '0;
    if (w_grant) fifo_pop[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= AW_DS_IDLE;
      r_owner     <= IDXWIDTH'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_accept) out_valid <= w_grant;
      if (w_grant) begin
        out_data <= w_head[w_grant_idx];
        out_idx  <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hqm_aw_fifo_drain_sched.sv
// Directed bench for hqm_aw_fifo_drain_sched with a behavioural FIFO bank on the input side.
module tb_hqm_aw_fifo_drain_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cfg_enable;
  logic [15:0] cfg_weight;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_pop;
  logic [63:0] fifo_pop_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        sched_idle;

  int cnt [4];
  int seq [4];
  int pass_cnt;
  int chk_cnt;

  hqm_aw_fifo_drain_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_weight    (cfg_weight),
    .fifo_empty    (fifo_empty),
    .fifo_pop      (fifo_pop),
    .fifo_pop_data (fifo_pop_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .sched_idle    (sched_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Head word of FIFO i is {i, number of words already popped from i}.
  task automatic drive_fifos();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (cnt[i] == 0);
      fifo_pop_data[i*16 +: 16] = {4'(i), 12'(seq[i])};
    end
  endtask

  task automatic tick(output logic [3:0] p);
    #1;
    p = fifo_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        cnt[i]--;
        seq[i]++;
      end
    end
    drive_fifos();
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [15:0] wt,
                          input int c0, input int c1, input int c2, input int c3);
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    cfg_enable = en;
    cfg_weight = wt;
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    drive_fifos();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    cfg_enable = 4'hf;
    cfg_weight = 16'h1111;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; seq[i] = 0; end
    drive_fifos();
    #2;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data);
    else pass_cnt++;
    chk_cnt++;
    if (out_idx !== 2'd0) $display("FAIL reset_out_idx got %0d want 0", out_idx);
    else pass_cnt++;
    chk_cnt++;
    if (sched_idle !== 1'b1) $display("FAIL reset_sched_idle got %b want 1", sched_idle);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) cnt[i] = 10;
    drive_fifos();
    @(posedge clk);
    #1;
    chk_cnt++;
    if (fifo_pop !== 4'b0000) $display("FAIL reset_pop got %b want 0000", fifo_pop);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_idx [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] p;
    logic [3:0] ex;
    logic [15:0] ed;
    do_reset(4'hf, 16'h1111, 10, 10, 10, 10);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rr_valid_before got %b want 0", out_valid);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      ex = 4'(1 << exp_idx[k]);
      ed = {4'(exp_idx[k]), 12'(k / 4)};
      tick(p);
      chk_cnt++;
      if (p !== ex) $display("FAIL rr_pop[%0d] got %b want %b", k, p, ex);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx[k]))
        $display("FAIL rr_out[%0d] got v=%b idx=%0d want v=1 idx=%0d", k, out_valid, out_idx, exp_idx[k]);
      else pass_cnt++;
      chk_cnt++;
      if (out_data !== ed) $display("FAIL rr_data[%0d] got %h want %h", k, out_data, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_weighted();
    int exp_idx [10] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
    logic [3:0] p;
    do_reset(4'hf, 16'h2113, 20, 20, 20, 20);
    for (int k = 0; k < 10; k++) begin
      tick(p);
      chk_cnt++;
      if (out_idx !== 2'(exp_idx[k]) || out_valid !== 1'b1)
        $display("FAIL wrr_idx[%0d] got v=%b idx=%0d want v=1 idx=%0d", k, out_valid, out_idx, exp_idx[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] after [3] = '{4'b0001, 4'b0001, 4'b0010};
    logic [3:0] p;
    do_reset(4'hf, 16'h1114, 10, 10, 10, 10);
    for (int k = 0; k < 2; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== 4'b0001) $display("FAIL bp_pre_pop[%0d] got %b want 0001", k, p);
      else pass_cnt++;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== 4'b0000) $display("FAIL bp_stall_pop[%0d] got %b want 0000", k, p);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_idx !== 2'd0)
        $display("FAIL bp_stall_out[%0d] got v=%b d=%h idx=%0d want v=1 d=0001 idx=0",
                 k, out_valid, out_data, out_idx);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== after[k]) $display("FAIL bp_resume_pop[%0d] got %b want %b", k, p, after[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_short_fifo();
    logic [3:0] exp_p [3] = '{4'b0001, 4'b0001, 4'b0010};
    logic [3:0] p;
    do_reset(4'hf, 16'h1114, 2, 10, 10, 10);
    for (int k = 0; k < 3; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== exp_p[k]) $display("FAIL short_pop[%0d] got %b want %b", k, p, exp_p[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1)
      $display("FAIL short_no_bubble got v=%b idx=%0d want v=1 idx=1", out_valid, out_idx);
    else pass_cnt++;
  endtask

  task automatic test_single_requester();
    logic [3:0] p;
    do_reset(4'b0100, 16'h1111, 10, 10, 6, 10);
    for (int k = 0; k < 6; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== 4'b0100) $display("FAIL single_pop[%0d] got %b want 0100", k, p);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || sched_idle !== 1'b0)
      $display("FAIL single_last got v=%b idle=%b want v=1 idle=0", out_valid, sched_idle);
    else pass_cnt++;
    tick(p);
    chk_cnt++;
    if (p !== 4'b0000) $display("FAIL single_drained_pop got %b want 0000", p);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0 || sched_idle !== 1'b1)
      $display("FAIL single_idle got v=%b idle=%b want v=0 idle=1", out_valid, sched_idle);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'h2005 || out_idx !== 2'd2)
      $display("FAIL single_hold got d=%h idx=%0d want d=2005 idx=2", out_data, out_idx);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] p;
    do_reset(4'b0010, 16'h1141, 10, 10, 10, 10);
    for (int k = 0; k < 2; k++) begin
      tick(p);
      chk_cnt++;
      if (p !== 4'b0010) $display("FAIL rstmid_pop[%0d] got %b want 0010", k, p);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid);
    else pass_cnt++;
    cfg_enable = 4'hf;
    #1;
    chk_cnt++;
    if (fifo_pop !== 4'b0000) $display("FAIL rstmid_pop_held got %b want 0000", fifo_pop);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(p);
    chk_cnt++;
    if (p !== 4'b0001) $display("FAIL rstmid_first_grant got %b want 0001", p);
    else pass_cnt++;
    chk_cnt++;
    if (out_idx !== 2'd0 || out_valid !== 1'b1)
      $display("FAIL rstmid_out got v=%b idx=%0d want v=1 idx=0", out_valid, out_idx);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_back_pressure();
    test_short_fifo();
    test_single_requester();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hqm_aw_fifo_drain_sched.md
# hqm_AW_fifo_drain_sched

Weighted round-robin drain scheduler. It shares one downstream output port between NUM_REQ `hqm_AW_fifo_control`-style FIFOs. Each cycle it picks at most one non-empty, enabled FIFO, pulses that FIFO's pop, and captures the head data into a registered ready/valid output stage. It sits between a bank of per-source FIFOs and a single consumer pipe.

## Interface
Parameters:
- NUM_REQ, 4, number of FIFOs (requesters); legal 2..16.
- DWIDTH, 16, data width per FIFO.
- WTWIDTH, 4, width of each per-requester weight.
- IDXWIDTH, AW_logb2(NUM_REQ-1)+1, requester index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_enable  in  NUM_REQ  per-requester enable; quasi-static, may change any cycle.
- cfg_weight  in  NUM_REQ*WTWIDTH  requester i occupies bits [i*WTWIDTH +: WTWIDTH]; max consecutive pops per turn; 0 is treated as 1.
- fifo_empty  in  NUM_REQ  per-FIFO empty flag.
- fifo_pop  out  NUM_REQ  one-hot-or-zero pop strobe.
- fifo_pop_data  in  NUM_REQ*DWIDTH  head data of each FIFO; valid in the same cycle as pop when not empty.
- out_valid  out  1  output stage holds data.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  DWIDTH  registered data.
- out_idx  out  IDXWIDTH  source requester of out_data.
- sched_idle  out  1  out_valid=0 and no eligible requester.

## Operation
- eligible[i] = cfg_enable[i] & ~fifo_empty[i].
- accept = ~out_valid | out_ready. No pop occurs unless accept=1.
- Registered state:
  - state is IDLE or BURST.
  - owner holds the last granted index.
  - burst_cnt is WTWIDTH bits.
- Grant rule, when accept=1 and |eligible:
  - Continue the burst if state=BURST, eligible[owner]=1, and burst_cnt < max(weight[owner],1)-1. Grant owner and increment burst_cnt.
  - Otherwise grant the first eligible index scanning owner+1, owner+2, … with wrap modulo NUM_REQ. owner itself is scanned last. Set owner to that index, burst_cnt=0, state=BURST.
- When accept=1 and no requester is eligible: state←IDLE. owner is retained so the round-robin position is preserved.
- On a grant:
  - fifo_pop[g]=1.
  - out_data←fifo_pop_data[g], out_idx←g, out_valid←1.
- When accept=1 with no grant: out_valid←0. out_data and out_idx hold their values.
- Boundary cases:
  - Owner goes empty or is disabled mid-burst: the burst ends immediately and the next eligible requester is granted in the same cycle. No bubble.
  - A single eligible requester is re-granted every cycle. Its burst_cnt restarts at 0 after each full weight.
  - A weight change mid-burst takes effect on the next burst_cnt compare.
  - Backpressure (out_valid=1, out_ready=0): no pop; out_data, out_idx, owner and burst_cnt are all frozen.
- Reset values:
  - out_valid=0, out_data=0, out_idx=0.
  - fifo_pop=0 while reset is asserted.
  - state=IDLE, owner=NUM_REQ-1 (so the first grant is requester 0), burst_cnt=0.
  - sched_idle=1.

## Timing
- fifo_pop is combinational from registered state, fifo_empty, cfg_* and out_ready. This path is documented for synthesis.
- Data latency: pop in cycle N produces out_valid and out_data in cycle N+1.
- Sustained throughput is 1 pop/cycle while out_ready=1.
- out_data and out_idx change only on cycles with a grant.
- Reset assertion mid-burst clears all state asynchronously. A popped word still in the output stage is discarded, and the upstream owner accounts for it.

## Structure
- The state enum (IDLE, BURST) goes in hqm_AW_pkg as aw_drain_sched_state_t for reuse by sibling schedulers.
- One sub-module, hqm_AW_rr_next_sel:
  - Parameterized by NUM_REQ.
  - Inputs: request vector and pointer.
  - Outputs: a found flag and the first set index strictly after the pointer, with wrap.
  - Purely combinational.
- The rest of the block is a single always_comb grant/next-state block plus one always_ff for state and output stage.

## Test plan
- Weights all 1, all 4 FIFOs non-empty, out_ready=1 → fifo_pop order 0,1,2,3,0,1. out_valid rises the cycle after the first pop, and out_idx follows one cycle behind the pops.
- Weights {3,1,1,2}, all FIFOs non-empty → out_idx sequence 0,0,0,1,2,3,3,0,0,0.
- out_ready=0 for 5 cycles while out_valid=1 → fifo_pop=0 and out_data stable. On release the same burst resumes, and burst_cnt is not reset.
- Weight[0]=4 but FIFO0 holds only 2 entries → pops 0,0, then requester 1 in the next cycle with no idle cycle.
- Only cfg_enable[2]=1, weight 1, FIFO2 holds 6 entries → 6 consecutive pops of requester 2, then sched_idle=1 and out_valid=0 after the drain.
- rst_n asserted mid-burst on requester 1 → out_valid=0 immediately. After release with all FIFOs non-empty, the first grant is requester 0.
